// File: rtl/tm1638_types.sv
// Shared TM1638 definitions: command bytes, SPI FIFO frame codes,
// display engine state encoding and the 18-bit word builder.
package tm1638_types;

    localparam logic [7:0] CMD_DATA_AUTO  = 8'h40;
    localparam logic [7:0] CMD_DATA_FIXED = 8'h44;
    localparam logic [7:0] CMD_ADDR       = 8'hC0;
    localparam logic [7:0] CMD_CTRL_ON    = 8'h88;
    localparam logic [7:0] CMD_CTRL_OFF   = 8'h80;

    // Frame code carried in word bits [17:16]; tells the SPI master how to handle STB
    typedef enum logic [1:0] {
        FR_SINGLE = 2'b00,
        FR_PAIR   = 2'b01,
        FR_OPEN   = 2'b10,
        FR_CLOSE  = 2'b11
    } frame_code_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DCMD_SEG,
        ST_ADDR_SEG,
        ST_DCMD_LED,
        ST_ADDR_LED,
        ST_BURST_CMD,
        ST_BURST_ADDR,
        ST_BURST_DATA,
        ST_CTRL,
        ST_DONE
    } engine_state_t;

    // Single-byte codes pass hi = 0 so unused bits stay clear
    function automatic logic [17:0] make_word(input frame_code_t code,
                                              input logic [7:0]  hi,
                                              input logic [7:0]  lo);
        return {code, hi, lo};
    endfunction

endpackage

// File: rtl/tm1638_refresh_timer.sv
// Idle-time counter that pulses o_Tick when the engine has been idle for
// REFRESH_CYCLES cycles. REFRESH_CYCLES = 0 removes the counter entirely.
module tm1638_refresh_timer #(
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Idle,
    output logic o_Tick
);

    generate
        if (REFRESH_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, i_Clk, i_Rst, i_Idle};
            assign o_Tick        = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

            logic [CW-1:0] count;

            // Count idle cycles; any non-idle cycle or the terminal count restarts from zero
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    count <= '0;
                end else if (!i_Idle || count == LAST) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            assign o_Tick = i_Idle && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/tm1638_display_engine.sv
// TM1638 display engine: latches a digit/LED frame and serialises it into
// framed 18-bit words for the SPI FIFO, in fixed-address or burst mode,
// finishing with the display control byte. Optional idle-time refresh.
module tm1638_display_engine
    import tm1638_types::*;
#(
    parameter int unsigned DIGITS         = 8,
    parameter int unsigned REFRESH_CYCLES = 0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [DIGITS*8-1:0]   i_Segments,
    input  logic [DIGITS-1:0]     i_Leds,
    input  logic [2:0]            i_Brightness,
    input  logic                  i_Display_On,
    input  logic                  i_Auto_Inc,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_SPI_FIFO_Full,
    output logic [17:0]           o_Data,
    output logic                  o_Write,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW = $clog2(2 * DIGITS) + 1;
    localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [BW-1:0] LAST_BYTE  = BW'(2 * DIGITS - 1);

    engine_state_t state, state_next;

    logic [DIGITS-1:0][7:0] seg_q;
    logic [DIGITS-1:0]      led_q;
    logic [2:0]             bright_q;
    logic                   on_q;
    logic                   auto_q;

    logic [DW-1:0] digit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [DW-1:0] byte_digit;
    logic [7:0]    digit_addr;
    logic [7:0]    burst_byte;
    logic [7:0]    ctrl_byte;

    logic accept;
    logic refresh_tick;

    assign accept = i_Valid && (state == ST_IDLE);

    tm1638_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Idle (state == ST_IDLE),
        .o_Tick (refresh_tick)
    );

    // State register
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame latch: captured only on an accepted offer, reused by refresh
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            seg_q    <= '0;
            led_q    <= '0;
            bright_q <= '0;
            on_q     <= 1'b0;
            auto_q   <= 1'b0;
        end else if (accept) begin
            seg_q    <= i_Segments;
            led_q    <= i_Leds;
            bright_q <= i_Brightness;
            on_q     <= i_Display_On;
            auto_q   <= i_Auto_Inc;
        end
    end

    // Digit and byte counters: cleared in IDLE, advanced only when a word is pushed
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            digit_cnt <= '0;
            byte_cnt  <= '0;
        end else if (state == ST_IDLE) begin
            digit_cnt <= '0;
            byte_cnt  <= '0;
        end else if (o_Write) begin
            if (state == ST_ADDR_LED) begin
                digit_cnt <= digit_cnt + 1'b1;
            end
            if (state == ST_BURST_DATA) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // Next-state: every emit state holds until its word is actually written
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = i_Auto_Inc ? ST_BURST_CMD : ST_DCMD_SEG;
                end else if (refresh_tick) begin
                    state_next = auto_q ? ST_BURST_CMD : ST_DCMD_SEG;
                end
            end
            ST_DCMD_SEG:   if (o_Write) state_next = ST_ADDR_SEG;
            ST_ADDR_SEG:   if (o_Write) state_next = ST_DCMD_LED;
            ST_DCMD_LED:   if (o_Write) state_next = ST_ADDR_LED;
            ST_ADDR_LED: begin
                if (o_Write) begin
                    state_next = (digit_cnt == LAST_DIGIT) ? ST_CTRL : ST_DCMD_SEG;
                end
            end
            ST_BURST_CMD:  if (o_Write) state_next = ST_BURST_ADDR;
            ST_BURST_ADDR: if (o_Write) state_next = ST_BURST_DATA;
            ST_BURST_DATA: if (o_Write && byte_cnt == LAST_BYTE) state_next = ST_CTRL;
            ST_CTRL:       if (o_Write) state_next = ST_DONE;
            ST_DONE:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Outputs: word contents decoded from state and counters, write gated by FIFO full
    always_comb begin
        byte_digit = DW'(byte_cnt >> 1);
        digit_addr = CMD_ADDR | {3'b000, 4'(digit_cnt), 1'b0};
        burst_byte = byte_cnt[0] ? {7'b0, led_q[byte_digit]} : seg_q[byte_digit];
        ctrl_byte  = on_q ? (CMD_CTRL_ON | {5'b0, bright_q}) : CMD_CTRL_OFF;

        o_Data  = '0;
        o_Write = 1'b0;
        o_Ready = (state == ST_IDLE);
        o_Busy  = (state != ST_IDLE);
        o_Done  = (state == ST_DONE);

        unique case (state)
            ST_DCMD_SEG,
            ST_DCMD_LED:   o_Data = make_word(FR_SINGLE, 8'h00, CMD_DATA_FIXED);
            ST_ADDR_SEG:   o_Data = make_word(FR_PAIR, digit_addr, seg_q[digit_cnt]);
            ST_ADDR_LED:   o_Data = make_word(FR_PAIR, digit_addr | 8'h01, {7'b0, led_q[digit_cnt]});
            ST_BURST_CMD:  o_Data = make_word(FR_SINGLE, 8'h00, CMD_DATA_AUTO);
            ST_BURST_ADDR: o_Data = make_word(FR_OPEN, 8'h00, CMD_ADDR);
            ST_BURST_DATA: o_Data = make_word((byte_cnt == LAST_BYTE) ? FR_CLOSE : FR_OPEN,
                                              8'h00, burst_byte);
            ST_CTRL:       o_Data = make_word(FR_SINGLE, 8'h00, ctrl_byte);
            default:       o_Data = '0;
        endcase

        if (state != ST_IDLE && state != ST_DONE) begin
            o_Write = !i_SPI_FIFO_Full;
        end
    end

endmodule
